// File: rtl/fp_divsqrt_seq.sv
// Radix-2 mantissa divide / square-root engine: one result bit per clock, done 26 cycles after start.
// A start is taken only while idle; a start that arrives while busy is dropped.
module fp_divsqrt_seq #(
  parameter int ITER = 26
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic        op_sqrt,
  input  logic [23:0] a,
  input  logic [23:0] b,
  input  logic [25:0] x,
  output logic [25:0] q,
  output logic        sticky,
  output logic        dz,
  output logic        busy,
  output logic        done,
  output logic [4:0]  count_div,
  output logic [4:0]  count_sqrt
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_RUN    = 1'b1;
  localparam logic [4:0] CNT_LOAD = 5'(ITER);

  logic [0:0]  r_state;
  logic        r_op_sqrt;
  logic [4:0]  r_cnt;
  logic [23:0] r_b;
  logic [24:0] r_drem;
  logic [25:0] r_dvd;
  logic [25:0] r_srem_lo;
  logic        r_sneg;
  logic [25:0] r_rad;
  logic [25:0] r_q;
  logic        r_sticky;
  logic        r_dz;
  logic        r_done;

  logic [25:0] w_dshift;
  logic [25:0] w_dtrial;
  logic        w_dbit;
  logic [25:0] w_dsel;
  logic [27:0] w_sshift;
  logic [27:0] w_srem_nxt;
  logic        w_sbit;
  logic [25:0] w_sq_nxt;
  logic [27:0] w_srem_fix;
  logic        w_bit;
  logic        w_sticky;
  logic        w_last;
  logic        w_dz;

  // Restoring divide; the shifted remainder stays below 2^25, so bit 25 of the trial is its sign.
  assign w_dshift = {r_drem, r_dvd[25]};
  assign w_dtrial = w_dshift - {2'b00, r_b};
  assign w_dbit   = ~w_dtrial[25];
  assign w_dsel   = w_dbit ? w_dtrial : w_dshift;

  // Non-restoring sqrt in 28-bit two's complement; only the sign and low 26 bits feed the next step.
  assign w_sshift   = {r_srem_lo, r_rad[25:24]};
  assign w_srem_nxt = r_sneg ? (w_sshift + {r_q, 2'b11}) : (w_sshift - {r_q, 2'b01});
  assign w_sbit     = ~w_srem_nxt[27];
  assign w_sq_nxt   = {r_q[24:0], w_sbit};
  assign w_srem_fix = w_srem_nxt[27] ? (w_srem_nxt + {1'b0, w_sq_nxt, 1'b1}) : w_srem_nxt;

  assign w_bit    = r_op_sqrt ? w_sbit : w_dbit;
  assign w_sticky = r_op_sqrt ? (|w_srem_fix) : (|w_dsel);
  assign w_last   = (r_cnt == 5'd1);
  assign w_dz     = ~op_sqrt & (b == 24'd0);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_op_sqrt <= 1'b0;
      r_cnt     <= '0;
      r_b       <= '0;
      r_drem    <= '0;
      r_dvd     <= '0;
      r_srem_lo <= '0;
      r_sneg    <= 1'b0;
      r_rad     <= '0;
      r_q       <= '0;
      r_sticky  <= 1'b0;
      r_dz      <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (start) begin
          r_op_sqrt <= op_sqrt;
          r_b       <= b;
          // a>>1 < b, so the top 23 dividend bits sit in the remainder and yield no quotient bits.
          r_drem    <= {2'b00, a[23:1]};
          r_dvd     <= {a[0], 25'd0};
          r_srem_lo <= '0;
          r_sneg    <= 1'b0;
          r_rad     <= x;
          if (w_dz) begin
            r_q      <= '1;
            r_sticky <= 1'b1;
            r_dz     <= 1'b1;
            r_done   <= 1'b1;
          end else begin
            r_state  <= S_RUN;
            r_cnt    <= CNT_LOAD;
            r_q      <= '0;
            r_sticky <= 1'b0;
            r_dz     <= 1'b0;
          end
        end
      end else begin
        r_cnt     <= r_cnt - 5'd1;
        r_q       <= {r_q[24:0], w_bit};
        r_drem    <= w_dsel[24:0];
        r_dvd     <= {r_dvd[24:0], 1'b0};
        r_srem_lo <= w_srem_nxt[25:0];
        r_sneg    <= w_srem_nxt[27];
        r_rad     <= {r_rad[23:0], 2'b00};
        if (w_last) begin
          r_state  <= S_IDLE;
          r_done   <= 1'b1;
          r_sticky <= w_sticky;
        end
      end
    end
  end

  assign q          = r_q;
  assign sticky     = r_sticky;
  assign dz         = r_dz;
  assign busy       = (r_state == S_RUN);
  assign done       = r_done;
  assign count_div  = r_op_sqrt ? 5'd0 : r_cnt;
  assign count_sqrt = r_op_sqrt ? r_cnt : 5'd0;

endmodule

// File: tb/tb_fp_divsqrt_seq.sv
// Directed bench for fp_divsqrt_seq with hand-computed results.
module tb_fp_divsqrt_seq;

  logic        clock;
  logic        resetn;
  logic        start;
  logic        op_sqrt;
  logic [23:0] a;
  logic [23:0] b;
  logic [25:0] x;
  logic [25:0] q;
  logic        sticky;
  logic        dz;
  logic        busy;
  logic        done;
  logic [4:0]  count_div;
  logic [4:0]  count_sqrt;

  int tests = 0;
  int fails = 0;

  fp_divsqrt_seq #(.ITER(26)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .op_sqrt    (op_sqrt),
    .a          (a),
    .b          (b),
    .x          (x),
    .q          (q),
    .sticky     (sticky),
    .dz         (dz),
    .busy       (busy),
    .done       (done),
    .count_div  (count_div),
    .count_sqrt (count_sqrt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, ".q"},      32'(q),          32'h0);
    chk({tag, ".sticky"}, 32'(sticky),     32'h0);
    chk({tag, ".dz"},     32'(dz),         32'h0);
    chk({tag, ".busy"},   32'(busy),       32'h0);
    chk({tag, ".done"},   32'(done),       32'h0);
    chk({tag, ".cdiv"},   32'(count_div),  32'h0);
    chk({tag, ".csqrt"},  32'(count_sqrt), 32'h0);
  endtask

  // Launches an op at the current time (after an edge), checks per-cycle counters,
  // latency and result. poke>0 raises start with different operands before edge 'poke'.
  task automatic run_op(input string tag, input logic op, input logic [23:0] ia,
                        input logic [23:0] ib, input logic [25:0] ix,
                        input logic [25:0] eq, input logic est, input int poke);
    int lat;
    lat = 0;
    op_sqrt = op; a = ia; b = ib; x = ix; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    chk({tag, ".done_drop"}, 32'(done), 32'h0);
    chk({tag, ".busy"},      32'(busy), 32'h1);
    chk({tag, ".cnt26"},     32'(op ? count_sqrt : count_div), 32'd26);
    for (int k = 1; k <= 40; k++) begin
      if (k == poke) begin
        start = 1'b1; op_sqrt = ~op; a = 24'h800000; b = 24'hFFFFFF; x = 26'h3FFFFFF;
      end
      @(posedge clock); #1; start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
      chk({tag, ".cnt"},   32'(op ? count_sqrt : count_div), 32'(26 - k));
      chk({tag, ".other"}, 32'(op ? count_div : count_sqrt), 32'h0);
    end
    chk({tag, ".latency"}, 32'(lat),        32'd26);
    chk({tag, ".q"},       32'(q),          32'(eq));
    chk({tag, ".sticky"},  32'(sticky),     32'(est));
    chk({tag, ".dz"},      32'(dz),         32'h0);
    chk({tag, ".busy_end"},32'(busy),       32'h0);
    chk({tag, ".cdiv_end"},32'(count_div),  32'h0);
    chk({tag, ".csq_end"}, 32'(count_sqrt), 32'h0);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; op_sqrt = 1'b0;
    a = 24'h0; b = 24'h0; x = 26'h0;
    #1;
    chk_idle_zero("reset");
    repeat (2) @(posedge clock);
    @(negedge clock); resetn = 1'b1;
    @(posedge clock); #1;

    // Divides, sqrts, each launched in the done cycle of the one before it.
    run_op("div_1_1",  1'b0, 24'h800000, 24'h800000, 26'h0,       26'h2000000, 1'b0, 0);
    run_op("div_3_2",  1'b0, 24'hC00000, 24'h800000, 26'h0,       26'h3000000, 1'b0, 0);
    run_op("div_2_3",  1'b0, 24'h800000, 24'hC00000, 26'h0,       26'h1555555, 1'b1, 0);
    run_op("sqrt_1",   1'b1, 24'h0,      24'h0,      26'h1000000, 26'h2000000, 1'b0, 0);
    run_op("sqrt_2",   1'b1, 24'hC00000, 24'h0,      26'h2000000, 26'h2D413CC, 1'b1, 0);
    run_op("div_poke", 1'b0, 24'hC00000, 24'h800000, 26'h0,       26'h3000000, 1'b0, 5);
    run_op("b2b_div",  1'b0, 24'h800000, 24'hC00000, 26'h0,       26'h1555555, 1'b1, 0);
    run_op("b2b_sqrt", 1'b1, 24'h0,      24'h0,      26'h2000000, 26'h2D413CC, 1'b1, 0);

    // Divide by zero: one-cycle turnaround, never busy.
    op_sqrt = 1'b0; a = 24'hC00000; b = 24'h0; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    chk("dz.done",   32'(done),      32'h1);
    chk("dz.dz",     32'(dz),        32'h1);
    chk("dz.q",      32'(q),         32'h3FFFFFF);
    chk("dz.sticky", 32'(sticky),    32'h1);
    chk("dz.busy",   32'(busy),      32'h0);
    chk("dz.cdiv",   32'(count_div), 32'h0);
    @(posedge clock); #1;
    chk("dz.done_drop", 32'(done), 32'h0);
    chk("dz.q_hold",    32'(q),    32'h3FFFFFF);
    chk("dz.dz_hold",   32'(dz),   32'h1);
    chk("dz.busy2",     32'(busy), 32'h0);

    // Reset asserted after 10 iterations of 2/3.
    op_sqrt = 1'b0; a = 24'h800000; b = 24'hC00000; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    chk("rst.q_mid",  32'(q),         32'h155);
    chk("rst.c_mid",  32'(count_div), 32'd16);
    #2; resetn = 1'b0;
    #1;
    chk_idle_zero("rst_async");
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      chk("rst.no_done", 32'(done), 32'h0);
    end
    @(negedge clock); resetn = 1'b1;
    @(posedge clock); #1;
    chk("rst.idle_done", 32'(done), 32'h0);
    run_op("post_rst", 1'b0, 24'h800000, 24'h800000, 26'h0, 26'h2000000, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_divsqrt_seq.md
Name: fp_divsqrt_seq

Overview:
- Iterative radix-2 mantissa divide / square-root engine for the FPU pipeline.
- Sits beside the FPU's E1 stage. E1 hands it normalized mantissas on an fdiv/fsqrt. It returns a 26-bit root/quotient plus sticky bit for the E2/E3 round-and-pack path.
- Provides the per-unit iteration counters (count_div, count_sqrt) and the busy signal that the pipeline stall logic consumes.

Parameters:
- ITER, 26, iterations per operation; equals result width in bits.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request a new operation; sampled only when idle.
- op_sqrt  in  1  0 = divide, 1 = square root; sampled with start.
- a  in  24  divide: dividend mantissa incl. hidden bit, range [2^23, 2^24).
- b  in  24  divide: divisor mantissa incl. hidden bit, range [2^23, 2^24).
- x  in  26  sqrt: radicand pre-aligned upstream for odd/even exponent, range [2^24, 2^26).
- q  out  26  result: divide = floor(a*2^25/b); sqrt = floor(sqrt(x*2^26)).
- sticky  out  1  1 when the final partial remainder is nonzero.
- dz  out  1  divide-by-zero flag (b == 0 on a divide).
- busy  out  1  operation in progress; drives FPU stall.
- done  out  1  one-cycle pulse when q/sticky/dz become valid.
- count_div  out  5  remaining divide iterations; 0 when idle or running sqrt.
- count_sqrt  out  5  remaining sqrt iterations; 0 when idle or running divide.

Behaviour:
- Reset (async, resetn=0): state IDLE; q=0, sticky=0, dz=0, busy=0, done=0, count_div=0, count_sqrt=0. Reset mid-operation aborts with no done pulse.
- States: IDLE, RUN.
- IDLE -> RUN: on an edge with start=1.
  - Capture operands and op_sqrt.
  - Clear the partial remainder.
  - Load the active counter with ITER (26); busy=1.
  - Clear dz and sticky.
  - q is cleared on entry to RUN.
- RUN: each edge performs one iteration and decrements the active counter.
  - Divide: restoring. Trial = (rem<<1 | next dividend bit) - b; if nonnegative, keep it and emit quotient bit 1, else emit 0. Dividend is a extended by 25 zero LSBs. Remainder width is 25 bits.
  - Sqrt: non-restoring digit recurrence on a 52-bit radicand x<<26, consuming 2 bits per iteration. Remainder is 28 bits signed. A final remainder correction is applied before sticky evaluation.
- RUN -> IDLE: on the edge where the counter goes 1 -> 0.
  - q and sticky are valid, busy=0, done=1 for exactly the following cycle.
  - Latency: done is visible 26 cycles after the capture edge.
- Results hold in q/sticky/dz until the next accepted start.
- start while busy=1 is ignored: no queuing, operands not sampled. The pipeline guarantees it stalls instead.
- start in the same cycle done=1 is accepted, since the state is IDLE; done still drops on the next edge.
- Divide with b==0: no iterations run. Next edge gives q=all ones, sticky=1, dz=1, done=1, busy never asserted. Latency is 1.
- Sqrt ignores a/b; divide ignores x. dz is only set by divide.
- Operands outside the stated ranges give unspecified q, but the FSM timing is unchanged.

Test Plan:
- Reset asserted mid-RUN at iteration 10 -> outputs all zero immediately (async), no done pulse; a following start runs the full 26 cycles.
- Divide a=0x800000, b=0x800000 -> after 26 cycles done=1, q=0x2000000, sticky=0, count_div sequence 26..1 then 0.
- Divide a=0xC00000, b=0x800000 -> q=0x3000000, sticky=0. Divide a=0x800000, b=0xC00000 -> q=0x1555555, sticky=1.
- Sqrt x=0x1000000 -> q=0x2000000, sticky=0. Sqrt x=0x2000000 -> q=0x2D413CC, sticky=1; count_sqrt counts, count_div stays 0.
- start pulsed at iteration 5 of a running divide -> ignored, result unchanged. Back-to-back start coincident with done -> second op accepted, done again 26 cycles later.
- Divide with b=0 -> next cycle done=1, dz=1, q=0x3FFFFFF, sticky=1, busy stays 0.
